// File: rtl/prime_divisor_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : prime_divisor_engine_if                                   |
// | Purpose  : Input and output valid/ready handshake bundle for the     |
// |            prime_divisor_engine. The master side supplies values and |
// |            consumes results; the slave side is the engine.           |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface prime_divisor_engine_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_prime;
    logic [4:0]       out_mul;

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        input  out_valid,
        output out_ready,
        input  out_prime,
        input  out_mul
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        output out_valid,
        input  out_ready,
        output out_prime,
        output out_mul
    );
endinterface
`default_nettype wire

// File: rtl/prime_divisor_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : prime_divisor_engine                                      |
// | Purpose  : Trial-division prime test of a WIDTH-bit unsigned value,  |
// |            one divisor per cycle, plus multiple-of flags for 2, 3,   |
// |            5, 7 and 11. Valid/ready handshakes on input and output.  |
// | Options  : PRIME_EARLY_EXIT_EN - finish right after divisor 11 when  |
// |            the value is already known to be composite.               |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module prime_divisor_engine #(
    parameter int WIDTH = 8
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    prime_divisor_engine_if.slave  bus
);
    localparam int DW = WIDTH + 1;       // divisor width
    localparam int PW = 2 * WIDTH + 2;   // divisor-square width, never truncates

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] n_q;
    logic [DW-1:0]    d_q;
    logic             composite_q;
    logic [4:0]       mul_acc_q;
    logic             out_valid_q;
    logic             out_prime_q;
    logic [4:0]       out_mul_q;

    logic [DW-1:0]    w_div;
    logic [DW-1:0]    w_rem;
    logic [DW-1:0]    w_d_next;
    logic [PW-1:0]    w_d_next_ext;
    logic [PW-1:0]    w_dd_next;
    logic             w_divides;
    logic             w_composite_d;
    logic [4:0]       w_hit;
    logic [4:0]       w_mul_acc_d;
    logic             w_last;

    // Divisor never reaches zero in CHECK; the guard only keeps the idle
    // modulo well defined.
    assign w_div     = (d_q == '0) ? DW'(1) : d_q;
    assign w_rem     = DW'(n_q) % w_div;
    assign w_divides = (w_rem == '0);

    // A divisor equal to n itself does not make n composite.
    assign w_composite_d = composite_q | (w_divides && (d_q < DW'(n_q)));

    // Tracked small divisors; n = 0 is a multiple of nothing here.
    assign w_hit[0] = (d_q == DW'(2));
    assign w_hit[1] = (d_q == DW'(3));
    assign w_hit[2] = (d_q == DW'(5));
    assign w_hit[3] = (d_q == DW'(7));
    assign w_hit[4] = (d_q == DW'(11));
    assign w_mul_acc_d = mul_acc_q |
                         ((w_divides && (n_q != '0)) ? w_hit : 5'b00000);

    // d is the last divisor L = max(11, isqrt(n)) exactly when d >= 11 and
    // (d+1)^2 already exceeds n.
    assign w_d_next     = d_q + DW'(1);
    assign w_d_next_ext = PW'(w_d_next);
    assign w_dd_next    = w_d_next_ext * w_d_next_ext;

`ifdef PRIME_EARLY_EXIT_EN
    assign w_last = ((d_q >= DW'(11)) && (w_dd_next > PW'(n_q))) ||
                    ((d_q == DW'(11)) && w_composite_d);
`else
    assign w_last = (d_q >= DW'(11)) && (w_dd_next > PW'(n_q));
`endif

    // Control FSM: accept, scan divisors, then present and hold the result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            d_q         <= '0;
            composite_q <= 1'b0;
            mul_acc_q   <= 5'b00000;
            out_valid_q <= 1'b0;
            out_prime_q <= 1'b0;
            out_mul_q   <= 5'b00000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        n_q         <= bus.in_data;
                        d_q         <= DW'(2);
                        composite_q <= 1'b0;
                        mul_acc_q   <= 5'b00000;
                        state_q     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    composite_q <= w_composite_d;
                    mul_acc_q   <= w_mul_acc_d;
                    if (w_last) begin
                        state_q <= S_DONE;
                    end else begin
                        d_q <= w_d_next;
                    end
                end
                S_DONE: begin
                    // First DONE cycle registers the verdict; afterwards the
                    // result is held until the consumer takes it.
                    if (!out_valid_q) begin
                        out_prime_q <= (n_q >= WIDTH'(2)) & ~composite_q;
                        out_mul_q   <= mul_acc_q;
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_prime = out_prime_q;
    assign bus.out_mul   = out_mul_q;

endmodule
`default_nettype wire

// File: tb/tb_prime_divisor_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_prime_divisor_engine                                   |
// | Purpose  : Directed self-checking bench for prime_divisor_engine     |
// |            (WIDTH=8) with hand-computed results and latencies.       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_prime_divisor_engine;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    prime_divisor_engine_if #(.WIDTH(8)) bus ();

    prime_divisor_engine #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Send one value, measure edges from accept to out_valid, check result,
    // optionally hold out_ready low for 'hold' cycles, then complete handshake.
    task automatic run(input logic [7:0] n, input int exp_lat, input logic exp_p,
                       input logic [4:0] exp_m, input int hold);
        int   edges;
        logic busy_ok;
        logic stable_ok;
        @(negedge clk);
        chk("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
        bus.in_data  = n;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        edges   = 0;
        busy_ok = 1'b1;
        while (!bus.out_valid && edges < 200) begin
            if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            edges++;
        end
        chk("latency", edges, exp_lat);
        chk("in_ready_busy", {31'd0, busy_ok}, 32'd1);
        chk("prime", {31'd0, bus.out_prime}, {31'd0, exp_p});
        chk("mul", {27'd0, bus.out_mul}, {27'd0, exp_m});
        if (hold > 0) begin
            stable_ok = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                bus.in_valid = 1'b1;
                bus.in_data  = 8'd4;
                @(posedge clk); #1;
                bus.in_valid = 1'b0;
                if (bus.out_valid !== 1'b1 || bus.out_prime !== exp_p ||
                    bus.out_mul !== exp_m || bus.in_ready !== 1'b0)
                    stable_ok = 1'b0;
            end
            chk("hold_stable", {31'd0, stable_ok}, 32'd1);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("valid_drop", {31'd0, bus.out_valid}, 32'd0);
        chk("ready_back", {31'd0, bus.in_ready}, 32'd1);
        chk("prime_held", {31'd0, bus.out_prime}, {31'd0, exp_p});
        chk("mul_held", {27'd0, bus.out_mul}, {27'd0, exp_m});
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'd0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_prime", {31'd0, bus.out_prime}, 32'd0);
        chk("rst_mul", {27'd0, bus.out_mul}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run(8'd13, 11, 1'b1, 5'b00000, 0);
`ifdef PRIME_EARLY_EXIT_EN
        run(8'd210, 11, 1'b0, 5'b01111, 0);
        run(8'd255, 11, 1'b0, 5'b00110, 0);
`else
        run(8'd210, 14, 1'b0, 5'b01111, 0);
        run(8'd255, 15, 1'b0, 5'b00110, 0);
`endif
        run(8'd0,   11, 1'b0, 5'b00000, 0);
        run(8'd1,   11, 1'b0, 5'b00000, 0);
        run(8'd2,   11, 1'b1, 5'b00001, 0);
        run(8'd121, 11, 1'b0, 5'b10000, 0);
        run(8'd251, 15, 1'b1, 5'b00000, 5);

        // Asynchronous reset in the 4th CHECK cycle of n=77.
        @(negedge clk);
        bus.in_data  = 8'd77;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("arst_prime", {31'd0, bus.out_prime}, 32'd0);
        chk("arst_mul", {27'd0, bus.out_mul}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run(8'd7, 11, 1'b1, 5'b01000, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
